// File: rtl/regfile_mp_if.sv
// Decode/writeback bus of the multi-port register file.
// Carries read, write, issue and scoreboard signals.
interface regfile_mp_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NR   = 2,
  parameter int NW   = 2
);
  localparam int AW = $clog2(NREG);

  logic [NR*AW-1:0]   ra;
  logic [NR*XLEN-1:0] rd;
  logic [NW-1:0]      we;
  logic [NW*AW-1:0]   wa;
  logic [NW*XLEN-1:0] wd;
  logic               iss_valid;
  logic [AW-1:0]      iss_addr;
  logic [NREG-1:0]    busy;
  logic [NR-1:0]      rd_busy;

  modport master (
    output ra, we, wa, wd, iss_valid, iss_addr,
    input  rd, busy, rd_busy
  );

  modport slave (
    input  ra, we, wa, wd, iss_valid, iss_addr,
    output rd, busy, rd_busy
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with write-first bypass.
// Optional issue scoreboard enabled by RF_SCOREBOARD_EN.
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int NR       = 2,
  parameter int NW       = 2,
  parameter int ZERO_REG = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  regfile_mp_if.slave  bus
);
  localparam int AW = $clog2(NREG);

  logic [XLEN-1:0]    mem [NREG];
  logic [NR*XLEN-1:0] rdata;
  logic [NR-1:0]      hit;
  logic [NR-1:0]      zr;

  // Later ports overwrite earlier ones: highest index wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NREG; k++)
        mem[k] <= '0;
    end else begin
      for (int j = 0; j < NW; j++)
        if (bus.we[j] &&
            !(ZERO_REG != 0 && bus.wa[j*AW +: AW] == '0))
          mem[bus.wa[j*AW +: AW]] <= bus.wd[j*XLEN +: XLEN];
    end
  end

  always_comb begin
    rdata = '0;
    hit   = '0;
    zr    = '0;
    for (int i = 0; i < NR; i++) begin
      rdata[i*XLEN +: XLEN] = mem[bus.ra[i*AW +: AW]];
      for (int j = 0; j < NW; j++)
        if (bus.we[j] &&
            bus.wa[j*AW +: AW] == bus.ra[i*AW +: AW]) begin
          hit[i] = 1'b1;
          rdata[i*XLEN +: XLEN] = bus.wd[j*XLEN +: XLEN];
        end
      if (ZERO_REG != 0 && bus.ra[i*AW +: AW] == '0) begin
        zr[i] = 1'b1;
        rdata[i*XLEN +: XLEN] = '0;
      end
    end
  end

  assign bus.rd = rdata;

`ifdef RF_SCOREBOARD_EN
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [NR-1:0]   rdb;

  // Clear on writeback first so a same-cycle issue wins.
  always_comb begin
    busy_d = busy_q;
    for (int j = 0; j < NW; j++)
      if (bus.we[j])
        busy_d[bus.wa[j*AW +: AW]] = 1'b0;
    if (bus.iss_valid)
      busy_d[bus.iss_addr] = 1'b1;
    if (ZERO_REG != 0)
      busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      busy_q <= '0;
    else
      busy_q <= busy_d;
  end

  always_comb begin
    rdb = '0;
    for (int i = 0; i < NR; i++)
      rdb[i] = busy_q[bus.ra[i*AW +: AW]] &
               ~hit[i] & ~zr[i];
  end

  assign bus.busy    = busy_q;
  assign bus.rd_busy = rdb;
`else
  logic unused_sb;

  assign unused_sb   = ^{bus.iss_valid, bus.iss_addr,
                         hit, zr};
  assign bus.busy    = '0;
  assign bus.rd_busy = '0;
`endif
endmodule

// File: tb/tb_regfile_mp.sv
// Directed-vector bench for regfile_mp.
// Scoreboard expectations follow RF_SCOREBOARD_EN.
module tb_regfile_mp;
  localparam int AW = 5;
`ifdef RF_SCOREBOARD_EN
  localparam logic SB = 1'b1;
`else
  localparam logic SB = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   vecs;
  int   errs;

  regfile_mp_if rf_if ();

  regfile_mp dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (rf_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int p,
                    input logic [AW-1:0] a,
                    input logic [31:0] d);
    rf_if.we[p]         = 1'b1;
    rf_if.wa[p*AW +: AW] = a;
    rf_if.wd[p*32 +: 32] = d;
  endtask

  task automatic rsel(input int p,
                      input logic [AW-1:0] a);
    rf_if.ra[p*AW +: AW] = a;
  endtask

  function automatic logic [31:0] rdp(input int p);
    return rf_if.rd[p*32 +: 32];
  endfunction

  initial begin
    vecs = 0;
    errs = 0;
    rst_n = 1'b0;
    rf_if.ra = '0;
    rf_if.we = '0;
    rf_if.wa = '0;
    rf_if.wd = '0;
    rf_if.iss_valid = 1'b0;
    rf_if.iss_addr  = '0;
    step();
    step();
    rst_n = 1'b1;
    #1;
    check("rst_busy", 64'(rf_if.busy), 64'h0);

    // reset clears a live entry asynchronously
    wr(0, 5'd5, 32'h1234_5678);
    step();
    rf_if.we = '0;
    rsel(0, 5'd5);
    #1;
    check("x5_wr", 64'(rdp(0)), 64'h1234_5678);
    #1 rst_n = 1'b0;
    #1;
    check("x5_async_rst", 64'(rdp(0)), 64'h0);
    check("busy_in_rst", 64'(rf_if.busy), 64'h0);
    check("rdb_in_rst", 64'(rf_if.rd_busy), 64'h0);
    step();
    rst_n = 1'b1;
    #1;
    check("x5_after_rst", 64'(rdp(0)), 64'h0);

    // write/read and x0 hardwiring
    wr(0, 5'd3, 32'hDEAD_BEEF);
    rsel(0, 5'd3);
    #1;
    check("x3_bypass", 64'(rdp(0)), 64'hDEAD_BEEF);
    step();
    rf_if.we = '0;
    #1;
    check("x3_stored", 64'(rdp(0)), 64'hDEAD_BEEF);
    wr(1, 5'd0, 32'hFFFF_FFFF);
    rsel(1, 5'd0);
    #1;
    check("x0_no_bypass", 64'(rdp(1)), 64'h0);
    step();
    rf_if.we = '0;
    #1;
    check("x0_stored", 64'(rdp(1)), 64'h0);

    // collision: port 1 wins, both for bypass and storage
    wr(0, 5'd7, 32'h11);
    wr(1, 5'd7, 32'h22);
    rsel(0, 5'd7);
    rsel(1, 5'd7);
    #1;
    check("x7_byp_p0", 64'(rdp(0)), 64'h22);
    check("x7_byp_p1", 64'(rdp(1)), 64'h22);
    step();
    rf_if.we = '0;
    #1;
    check("x7_stored", 64'(rdp(0)), 64'h22);
    check("x3_kept", 64'(dut.mem[3]), 64'hDEAD_BEEF);

    // scoreboard set, bypass masking, clear
    rf_if.iss_valid = 1'b1;
    rf_if.iss_addr  = 5'd9;
    rsel(0, 5'd9);
    #1;
    check("rdb_same_cyc", 64'(rf_if.rd_busy[0]), 64'h0);
    step();
    rf_if.iss_valid = 1'b0;
    #1;
    check("busy9_set", 64'(rf_if.busy[9]), 64'(SB));
    check("rdb9_set", 64'(rf_if.rd_busy[0]), 64'(SB));
    wr(0, 5'd9, 32'h99);
    #1;
    check("rdb9_byp", 64'(rf_if.rd_busy[0]), 64'h0);
    check("x9_byp", 64'(rdp(0)), 64'h99);
    check("busy9_hold", 64'(rf_if.busy[9]), 64'(SB));
    step();
    rf_if.we = '0;
    #1;
    check("busy9_clr", 64'(rf_if.busy), 64'h0);

    // set/clear collision: set wins
    rf_if.iss_valid = 1'b1;
    rf_if.iss_addr  = 5'd4;
    step();
    rf_if.iss_valid = 1'b0;
    #1;
    check("busy4_set", 64'(rf_if.busy),
          SB ? 64'h10 : 64'h0);
    wr(1, 5'd4, 32'h44);
    rf_if.iss_valid = 1'b1;
    rf_if.iss_addr  = 5'd4;
    step();
    rf_if.we = '0;
    rf_if.iss_valid = 1'b0;
    #1;
    check("busy4_collide", 64'(rf_if.busy),
          SB ? 64'h10 : 64'h0);
    rf_if.iss_valid = 1'b1;
    rf_if.iss_addr  = 5'd0;
    rsel(1, 5'd0);
    step();
    rf_if.iss_valid = 1'b0;
    #1;
    check("busy0_never", 64'(rf_if.busy[0]), 64'h0);
    check("rdb_x0", 64'(rf_if.rd_busy[1]), 64'h0);
    wr(1, 5'd4, 32'h45);
    step();
    rf_if.we = '0;
    #1;
    check("busy4_clr", 64'(rf_if.busy), 64'h0);
    rsel(0, 5'd4);
    #1;
    check("x4_stored", 64'(rdp(0)), 64'h45);

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file; successor to the single-write, dual-read register file in the pipeline's ID/WB path.
- Provides NR read ports and NW write ports with write-first bypass and asynchronous clear.
- Includes an optional register scoreboard that marks destinations busy at issue and clears them at writeback, so ID can stall on pending operands.
- Sits between decode (read ports, issue interface) and the writeback stages (write ports).

Parameters:
- XLEN, 32, data width in bits.
- NREG, 32, number of architectural registers; power of 2, 2..64. AW = $clog2(NREG) is derived, not overridable.
- NR, 2, number of read ports (1..4).
- NW, 2, number of write ports (1..3).
- ZERO_REG, 1, when 1, register 0 is hardwired to zero (writes dropped, reads return 0, never busy).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- ra  in  NR*AW  read addresses; port i at [i*AW +: AW].
- rd  out  NR*XLEN  read data; port i at [i*XLEN +: XLEN]; combinational.
- we  in  NW  per-port write enable.
- wa  in  NW*AW  write addresses.
- wd  in  NW*XLEN  write data.
- iss_valid  in  1  issue strobe; marks iss_addr pending.
- iss_addr  in  AW  destination register of the issued instruction.
- busy  out  NREG  scoreboard state, one bit per register; registered.
- rd_busy  out  NR  per-read-port operand-pending flag; combinational.

Behaviour:
- Reset (rst_n=0, asynchronous): all NREG entries go to 0 and busy goes to 0 immediately. rd then reads 0 on every port and rd_busy is 0. Release is synchronous to clk.
- Write: on posedge clk, each port j with we[j]=1 writes wd[j] to entry wa[j].
  - Same-address collision: the highest-index enabled port wins; lower ports to that address are dropped.
  - ZERO_REG=1 and wa[j]=0: that port's write is dropped.
- Read: combinational, zero latency.
  - Priority 1: ZERO_REG=1 and ra[i]=0 -> rd=0.
  - Priority 2: otherwise, if any we[j]=1 with wa[j]=ra[i], rd=wd[j] of the highest such j (write-first bypass).
  - Priority 3: otherwise, rd = stored entry.
  - Out-of-range addresses do not occur, since NREG is a power of 2.
- Scoreboard (registered, updated on posedge clk):
  - clear: busy[a] <= 0 for every a with some we[j]=1 and wa[j]=a.
  - set: busy[iss_addr] <= 1 when iss_valid=1.
  - Set and clear to the same address in one cycle -> set wins (new producer issued as old one retires).
  - ZERO_REG=1: issues to address 0 are ignored; busy[0] stays 0.
  - Issue to an already-busy register -> stays 1 (WAW is not tracked; the first writeback clears it).
- rd_busy[i] = busy[ra[i]] AND NOT (bypass hit on ra[i] this cycle) AND NOT (ZERO_REG and ra[i]=0).
  - The same-cycle iss_valid does not affect rd_busy; it is visible from the next cycle.
- Reset mid-operation: in-flight writes and issues in the reset cycle are lost; state is fully cleared.

Optional Feature:
- Macro: RF_SCOREBOARD_EN.
- Defined: scoreboard exactly as above.
- Undefined:
  - no busy flops; busy and rd_busy are tied to 0.
  - iss_valid and iss_addr are ignored.
  - the port list is unchanged.

Test Plan:
- Reset: hold rst_n=0 after writing x5=0x12345678; assert rd for ra=5 is 0x0 asynchronously and busy=0; release, read x5 -> 0x0.
- Write/read plus x0: we[0]=1, wa=3, wd=0xDEADBEEF, then read x3 next cycle -> 0xDEADBEEF. Write x0=0xFFFFFFFF -> reads of x0 return 0.
- Bypass priority: same cycle we[0] wa=7 wd=0x11, we[1] wa=7 wd=0x22, ra[0]=7 -> rd[0]=0x22 that cycle; x7 holds 0x22 afterward.
- Scoreboard: iss_valid, iss_addr=9 -> busy[9]=1 next cycle and rd_busy=1 for ra=9. Writeback we wa=9 -> rd_busy=0 in that same cycle (bypass), busy[9]=0 the cycle after.
- Set/clear collision: busy[4]=1; same cycle we wa=4 and iss_valid iss_addr=4 -> busy[4] remains 1. A later issue to x0 -> busy[0] stays 0.
- Build with RF_SCOREBOARD_EN undefined: repeat the scoreboard test -> busy and rd_busy always 0; data paths unchanged.
